// File: rtl/wb_regfile.sv
// Writeback select, integer register file (x0 hardwired to zero) and commit counter.
// Define WB_BYPASS_EN to forward the committing value to matching read ports in the same cycle.
module wb_regfile #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PC_W-1:0]  pc_next4_i,
  input  logic [XLEN-1:0]  mem_data_i,
  input  logic [XLEN-1:0]  ex_res_i,
  input  logic [4:0]       rd_i,
  input  logic             regwrite_i,
  input  logic             memtoreg_i,
  input  logic             jump_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             wb_we_o,
  output logic [CNT_W-1:0] commit_cnt_o
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] commit_cnt_q;
  logic [CNT_W-1:0] commit_cnt_d;

  always_comb begin
    if (jump_i) begin
      wb_data_o = XLEN'(pc_next4_i);
    end else if (memtoreg_i) begin
      wb_data_o = mem_data_i;
    end else begin
      wb_data_o = ex_res_i;
    end
  end

  assign wb_we_o = regwrite_i & (rd_i != '0) & ~rst_i;

  always_comb begin
    regs_d = regs_q;
    regs_d[0] = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (wb_we_o && (rd_i == i[4:0])) begin
        regs_d[i] = wb_data_o;
      end
    end
    commit_cnt_d = commit_cnt_q + (wb_we_o ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      commit_cnt_q <= '0;
    end else begin
      regs_q       <= regs_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign commit_cnt_o = commit_cnt_q;

  // Reads see the pre-write array unless write-through forwarding is built in.
  always_comb begin
    rs1_data_o = '0;
    rs2_data_o = '0;
    if (rs1_i != '0) begin
      rs1_data_o = regs_q[rs1_i];
    end
    if (rs2_i != '0) begin
      rs2_data_o = regs_q[rs2_i];
    end
`ifdef WB_BYPASS_EN
    if (wb_we_o && (rs1_i == rd_i)) begin
      rs1_data_o = wb_data_o;
    end
    if (wb_we_o && (rs2_i == rd_i)) begin
      rs2_data_o = wb_data_o;
    end
`endif
  end

endmodule
